// File: rtl/dsq_result_buffer.sv
// rtl/dsq_result_buffer.sv - div/sqrt result tracker and writeback FIFO
// Optional DSQ_BYPASS_EN: zero-latency bypass from ds_* to wb_* when the FIFO is empty.
module dsq_result_buffer #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5,
   parameter int RW    = 65
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             issue_fire_i,
   input  logic [TAG_W-1:0] issue_tag_i,
   input  logic             issue_typ_i,
   input  logic             issue_sqrt_i,
   input  logic             kill_i,
   input  logic             ds_valid_div_i,
   input  logic             ds_valid_sqrt_i,
   input  logic [RW-1:0]    ds_out_i,
   input  logic [4:0]       ds_exc_i,
   output logic             issue_ok_o,
   output logic             busy_o,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [RW-1:0]    wb_data_o,
   output logic [4:0]       wb_exc_o,
   output logic [TAG_W-1:0] wb_tag_o,
   output logic             wb_typ_o,
   output logic             wb_sqrt_o,
   output logic             err_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = RW + 5 + TAG_W + 2;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_INFLIGHT = 2'd1,
      S_DRAIN    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             typ_q, typ_d;
   logic             sqrt_q, sqrt_d;
   logic             err_q, err_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [EW-1:0]    mem_q [DEPTH];

   logic             pulse, both, push_req, full, bypass, do_push, do_pop;
   logic [EW-1:0]    push_entry, out_entry;

   assign pulse      = ds_valid_div_i | ds_valid_sqrt_i;
   assign both       = ds_valid_div_i & ds_valid_sqrt_i;
   assign full       = (count_q == CW'(DEPTH));
   assign issue_ok_o = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
   assign busy_o     = (state_q != S_IDLE) || (count_q != '0);
   assign err_o      = err_q;
   assign push_entry = {ds_out_i, ds_exc_i, tag_q, typ_q, sqrt_q};

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      typ_d    = typ_q;
      sqrt_d   = sqrt_q;
      err_d    = err_q;
      push_req = 1'b0;
      if (both) err_d = 1'b1;
      if (issue_fire_i && !issue_ok_o) err_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            // A pulse here has no owner, even if a new request issues alongside it.
            if (pulse) err_d = 1'b1;
            if (issue_fire_i && issue_ok_o) begin
               tag_d   = issue_tag_i;
               typ_d   = issue_typ_i;
               sqrt_d  = issue_sqrt_i;
               state_d = S_INFLIGHT;
            end
         end
         S_INFLIGHT: begin
            if (pulse) begin
               state_d = S_IDLE;
               if (!kill_i) begin
                  push_req = 1'b1;
                  if (!both && (ds_valid_sqrt_i != sqrt_q)) err_d = 1'b1;
               end
            end else if (kill_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pulse) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (push_req && full) err_d = 1'b1;
   end

   always_comb begin
`ifdef DSQ_BYPASS_EN
      bypass = push_req && (count_q == '0) && wb_ready_i;
`else
      bypass = 1'b0;
`endif
      do_push  = push_req && !full && !bypass;
      do_pop   = (count_q != '0) && wb_ready_i;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      out_entry  = mem_q[rd_ptr_q];
      wb_valid_o = (count_q != '0);
      if (bypass) begin
         out_entry  = push_entry;
         wb_valid_o = 1'b1;
      end
   end

   assign {wb_data_o, wb_exc_o, wb_tag_o, wb_typ_o, wb_sqrt_o} = out_entry;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= S_IDLE;
         tag_q    <= '0;
         typ_q    <= 1'b0;
         sqrt_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         typ_q    <= typ_d;
         sqrt_q   <= sqrt_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_entry;
      end
   end

endmodule

// File: tb/tb_dsq_result_buffer.sv
// tb/tb_dsq_result_buffer.sv - scoreboard bench for dsq_result_buffer
module tb_dsq_result_buffer;

   typedef struct packed {
      logic [64:0] data;
      logic [4:0]  exc;
      logic [4:0]  tag;
      logic        typ;
      logic        sqrt;
   } ent_t;

   logic        clk, reset_n;
   logic        issue_fire, issue_typ, issue_sqrt, kill;
   logic [4:0]  issue_tag;
   logic        ds_valid_div, ds_valid_sqrt;
   logic [64:0] ds_out;
   logic [4:0]  ds_exc;
   logic        issue_ok, busy, wb_valid, wb_ready, wb_typ, wb_sqrt, err;
   logic [64:0] wb_data;
   logic [4:0]  wb_exc, wb_tag;

   int   total = 0;
   int   bad   = 0;
   ent_t sb[$];

   dsq_result_buffer #(.DEPTH(2), .TAG_W(5), .RW(65)) dut (
      .clock_i(clk), .reset_i(reset_n),
      .issue_fire_i(issue_fire), .issue_tag_i(issue_tag), .issue_typ_i(issue_typ),
      .issue_sqrt_i(issue_sqrt), .kill_i(kill),
      .ds_valid_div_i(ds_valid_div), .ds_valid_sqrt_i(ds_valid_sqrt),
      .ds_out_i(ds_out), .ds_exc_i(ds_exc),
      .issue_ok_o(issue_ok), .busy_o(busy), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
      .wb_data_o(wb_data), .wb_exc_o(wb_exc), .wb_tag_o(wb_tag), .wb_typ_o(wb_typ),
      .wb_sqrt_o(wb_sqrt), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every accepted writeback must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset_n && wb_valid && wb_ready) begin
         ent_t got, exp;
         got = '{data: wb_data, exc: wb_exc, tag: wb_tag, typ: wb_typ, sqrt: wb_sqrt};
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected: got tag=%0d data=%h, expected nothing", wb_tag, wb_data);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL wb_entry: got %h, expected %h", got, exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_fire = 0; issue_tag = 0; issue_typ = 0; issue_sqrt = 0; kill = 0;
      ds_valid_div = 0; ds_valid_sqrt = 0; ds_out = '0; ds_exc = '0;
   endtask

   task automatic issue(input logic [4:0] tag, input logic typ, input logic sq);
      issue_fire = 1; issue_tag = tag; issue_typ = typ; issue_sqrt = sq;
      tick();
      issue_fire = 0;
   endtask

   task automatic pulse(input logic sq, input logic [64:0] d, input logic [4:0] e,
                        input logic expect_push, input logic [4:0] tag, input logic typ);
      ds_valid_div = ~sq; ds_valid_sqrt = sq; ds_out = d; ds_exc = e;
      if (expect_push) sb.push_back('{data: d, exc: e, tag: tag, typ: typ, sqrt: sq});
      tick();
      ds_valid_div = 0; ds_valid_sqrt = 0;
   endtask

   function automatic logic [64:0] rnd_data();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      reset_n = 0;
      idle_inputs();
      wb_ready = 0;
      repeat (3) tick();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b, expected 0", wb_valid); end
      total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL reset_issue_ok: got %b, expected 1", issue_ok); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, expected 0", err); end
      total++; if ({wb_data, wb_exc, wb_tag, wb_typ, wb_sqrt} !== '0) begin
         bad++; $display("FAIL reset_wb_fields: got %h, expected 0", {wb_data, wb_exc, wb_tag, wb_typ, wb_sqrt});
      end
      reset_n = 1;
      tick();
   endtask

   task automatic test_basic();
      wb_ready = 1;
      issue(5'd7, 1'b1, 1'b0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_inflight: got %b, expected 1", busy); end
      total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL basic_issue_ok_inflight: got %b, expected 0", issue_ok); end
      repeat (20) tick();
      pulse(1'b0, 65'h0_3FF0_0000_0000_0000, 5'd0, 1'b1, 5'd7, 1'b1);
`ifndef DSQ_BYPASS_EN
      total++; if (wb_valid !== 1'b1 || wb_tag !== 5'd7) begin
         bad++; $display("FAIL basic_latency: got valid=%b tag=%0d, expected valid=1 tag=7", wb_valid, wb_tag);
      end
`endif
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b, expected 0", busy); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_drained: got %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_stall();
      logic [64:0] da, db;
      da = rnd_data(); db = rnd_data();
      wb_ready = 0;
      issue(5'd1, 1'b0, 1'b0);
      pulse(1'b0, da, 5'h04, 1'b1, 5'd1, 1'b0);
      total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL stall_issue_ok_one: got %b, expected 1", issue_ok); end
      issue(5'd2, 1'b1, 1'b1);
      pulse(1'b1, db, 5'h10, 1'b1, 5'd2, 1'b1);
      total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL stall_issue_ok_full: got %b, expected 0", issue_ok); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wb_valid !== 1'b1 || wb_tag !== 5'd1 || wb_data !== da || wb_exc !== 5'h04) begin
            bad++; $display("FAIL stall_hold: got valid=%b tag=%0d data=%h, expected valid=1 tag=1 data=%h", wb_valid, wb_tag, wb_data, da);
         end
         tick();
      end
      wb_ready = 1;
      tick();
      total++; if (wb_valid !== 1'b1 || wb_tag !== 5'd2) begin
         bad++; $display("FAIL stall_second: got valid=%b tag=%0d, expected valid=1 tag=2", wb_valid, wb_tag);
      end
      tick();
      total++; if (wb_valid !== 1'b0 || sb.size() != 0) begin
         bad++; $display("FAIL stall_empty: got valid=%b pending=%0d, expected 0 0", wb_valid, sb.size());
      end
   endtask

   task automatic test_kill();
      wb_ready = 1;
      issue(5'd3, 1'b0, 1'b0);
      repeat (5) tick();
      kill = 1; tick(); kill = 0;
      total++; if (busy !== 1'b1 || issue_ok !== 1'b0) begin
         bad++; $display("FAIL kill_drain: got busy=%b issue_ok=%b, expected 1 0", busy, issue_ok);
      end
      repeat (2) tick();
      pulse(1'b0, rnd_data(), 5'h02, 1'b0, 5'd3, 1'b0);
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL kill_dropped: got valid=%b busy=%b err=%b, expected 0 0 0", wb_valid, busy, err);
      end
      issue(5'd4, 1'b0, 1'b1);
      pulse(1'b1, rnd_data(), 5'h08, 1'b1, 5'd4, 1'b0);
      repeat (2) tick();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL kill_next_tag: got %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_err_and_reset();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean: got %b, expected 0", err); end
      pulse(1'b1, rnd_data(), 5'h01, 1'b0, 5'd0, 1'b0);
      total++; if (err !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL err_idle_pulse: got err=%b valid=%b busy=%b, expected 1 0 0", err, wb_valid, busy);
      end
      repeat (3) tick();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b, expected 1", err); end
      issue(5'd9, 1'b1, 1'b0);
      reset_n = 0;
      #1;
      total++; if (issue_ok !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || wb_valid !== 1'b0 || wb_tag !== 5'd0) begin
         bad++; $display("FAIL async_reset: got ok=%b busy=%b err=%b valid=%b tag=%0d, expected 1 0 0 0 0", issue_ok, busy, err, wb_valid, wb_tag);
      end
      tick();
      reset_n = 1;
      tick();
      pulse(1'b0, rnd_data(), 5'h00, 1'b0, 5'd9, 1'b1);
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_abandon: got valid=%b, expected 0", wb_valid); end
      reset_n = 0; tick(); reset_n = 1; tick();
   endtask

   task automatic test_kill_same_and_illegal_issue();
      wb_ready = 1;
      issue(5'd5, 1'b0, 1'b0);
      repeat (2) tick();
      kill = 1; ds_valid_div = 1; ds_out = rnd_data();
      tick();
      kill = 0; ds_valid_div = 0;
      total++; if (busy !== 1'b0 || issue_ok !== 1'b1 || wb_valid !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL kill_same: got busy=%b ok=%b valid=%b err=%b, expected 0 1 0 0", busy, issue_ok, wb_valid, err);
      end
      wb_ready = 0;
      issue(5'd10, 1'b0, 1'b0);
      pulse(1'b0, rnd_data(), 5'h03, 1'b1, 5'd10, 1'b0);
      issue(5'd11, 1'b1, 1'b0);
      pulse(1'b0, rnd_data(), 5'h05, 1'b1, 5'd11, 1'b1);
      issue(5'd12, 1'b0, 1'b1);
      total++; if (err !== 1'b1 || busy !== 1'b1 || issue_ok !== 1'b0) begin
         bad++; $display("FAIL illegal_issue: got err=%b busy=%b ok=%b, expected 1 1 0", err, busy, issue_ok);
      end
      wb_ready = 1;
      repeat (3) tick();
      total++; if (sb.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL illegal_issue_ignored: got pending=%0d busy=%b, expected 0 0", sb.size(), busy);
      end
      reset_n = 0; tick(); reset_n = 1; tick();
   endtask

   task automatic test_bypass();
      logic [64:0] d;
      d = rnd_data();
      wb_ready = 1;
      issue(5'd6, 1'b0, 1'b0);
      ds_valid_div = 1; ds_out = d; ds_exc = 5'h01;
      sb.push_back('{data: d, exc: 5'h01, tag: 5'd6, typ: 1'b0, sqrt: 1'b0});
      #1;
`ifdef DSQ_BYPASS_EN
      total++; if (wb_valid !== 1'b1 || wb_exc !== 5'h01 || wb_data !== d) begin
         bad++; $display("FAIL bypass_same_cycle: got valid=%b exc=%h, expected 1 01", wb_valid, wb_exc);
      end
`else
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL no_bypass_path: got valid=%b, expected 0", wb_valid); end
`endif
      tick();
      ds_valid_div = 0;
`ifdef DSQ_BYPASS_EN
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL bypass_count: got valid=%b busy=%b, expected 0 0", wb_valid, busy);
      end
`else
      total++; if (wb_valid !== 1'b1 || wb_exc !== 5'h01) begin
         bad++; $display("FAIL latency_one: got valid=%b exc=%h, expected 1 01", wb_valid, wb_exc);
      end
`endif
      repeat (2) tick();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL bypass_drained: got %0d pending, expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_kill();
      test_err_and_reset();
      test_kill_same_and_illegal_issue();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
